reg_wb_arbiter: RTL and testbench

//  Write-back initiator for the 32x64 integer register file: merges ALU and LSU results

---
 rtl/reg_wb_arbiter_pkg.sv | 7 +
 rtl/reg_wb_arbiter_fifo.sv | 35 +++
 rtl/reg_wb_arbiter.sv | 74 +++++++
 tb/tb_reg_wb_arbiter.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/reg_wb_arbiter_pkg.sv
// reg_wb_arbiter_pkg: shared widths and grant encodings for the write-back arbiter
package reg_wb_arbiter_pkg;
    localparam int XLEN       = 64;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef enum logic {GNT_ALU = 1'b0, GNT_LSU = 1'b1} grant_e;
endpackage

// File: rtl/reg_wb_arbiter_fifo.sv
// wb_fifo: small synchronous FIFO buffering load results, extra pointer MSB separates full from empty
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 69
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    logic [AW:0]      wp, rp;
    logic [WIDTH-1:0] mem [DEPTH];
    assign empty = wp == rp;
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign head  = mem[rp[AW-1:0]];
    // read/write pointers; reset empties the queue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push) wp <= wp + 1'b1;
            if (pop) rp <= rp + 1'b1;
        end
    end
    // storage needs no reset: entries are only visible between the pointers
    always_ff @(posedge clk) begin
        if (push) mem[wp[AW-1:0]] <= din;
    end
endmodule

// File: rtl/reg_wb_arbiter.sv
// reg_wb_arbiter: merges ALU and load results onto the single regfile write port and tracks pending writes
module reg_wb_arbiter #(
    parameter int XLEN           = reg_wb_arbiter_pkg::XLEN,
    parameter int LSU_FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            alu_valid,
    output logic            alu_ready,
    input  logic [4:0]      alu_rd,
    input  logic [XLEN-1:0] alu_data,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [4:0]      lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic            iss_valid,
    input  logic [4:0]      iss_rd,
    output logic [31:0]     busy,
    output logic            rf_w_en,
    output logic [4:0]      rf_w_reg,
    output logic [XLEN-1:0] rf_w_data
);
    import reg_wb_arbiter_pkg::*;
    localparam int W = REG_ADDR_W + XLEN;
    logic                  fifo_full, fifo_empty, alu_gnt, lsu_gnt;
    logic [W-1:0]          head;
    logic [REG_ADDR_W-1:0] gnt_rd;
    logic [XLEN-1:0]       gnt_data;
    logic [NUM_REGS-1:0]   busy_set, busy_clr;
    grant_e                last_grant;
    // ALU only stalls when the buffered load is owed its turn; never looks at alu_valid
    assign alu_ready = !(!fifo_empty && last_grant == GNT_ALU);
    assign lsu_ready = !fifo_full;
    assign alu_gnt   = alu_valid && alu_ready;
    assign lsu_gnt   = !fifo_empty && !alu_gnt;
    assign gnt_rd    = alu_gnt ? alu_rd : head[W-1:XLEN];
    assign gnt_data  = alu_gnt ? alu_data : head[XLEN-1:0];
    wb_fifo #(.DEPTH(LSU_FIFO_DEPTH), .WIDTH(W)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (lsu_valid && lsu_ready),
        .pop   (lsu_gnt),
        .din   ({lsu_rd, lsu_data}),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (head)
    );
    // scoreboard set/clear masks; x0 is never tracked
    always_comb begin
        busy_set = '0;
        busy_clr = '0;
        if (iss_valid) busy_set[iss_rd] = 1'b1;
        if (rf_w_en) busy_clr[rf_w_reg] = 1'b1;
        busy_set[0] = 1'b0;
    end
    // grant history, registered write port and scoreboard (set beats clear)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_grant <= GNT_LSU;
            rf_w_en    <= 1'b0;
            rf_w_reg   <= '0;
            rf_w_data  <= '0;
            busy       <= '0;
        end else begin
            if (alu_gnt || lsu_gnt) begin
                last_grant <= alu_gnt ? GNT_ALU : GNT_LSU;
                rf_w_reg   <= gnt_rd;
                rf_w_data  <= gnt_data;
            end
            rf_w_en <= (alu_gnt || lsu_gnt) && gnt_rd != '0;
            busy    <= (busy & ~busy_clr) | busy_set;
        end
    end
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb_reg_wb_arbiter: directed checks of arbitration, load buffering, x0 drop, scoreboard and reset
module tb_reg_wb_arbiter;
    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready, iss_valid, rf_w_en;
    logic [4:0]  alu_rd, lsu_rd, iss_rd, rf_w_reg;
    logic [63:0] alu_data, lsu_data, rf_w_data;
    logic [31:0] busy;
    int          n_chk = 0;
    int          n_err = 0;
    logic [4:0]  wr_rd_q[$];
    logic [63:0] wr_data_q[$];

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk       (clk),
        .rstn      (rstn),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .iss_valid (iss_valid),
        .iss_rd    (iss_rd),
        .busy      (busy),
        .rf_w_en   (rf_w_en),
        .rf_w_reg  (rf_w_reg),
        .rf_w_data (rf_w_data)
    );

    // log every regfile write seen mid-cycle
    always @(negedge clk) begin
        if (rstn && rf_w_en) begin
            wr_rd_q.push_back(rf_w_reg);
            wr_data_q.push_back(rf_w_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // push loads with rising data until lsu_ready drops; acc = loads accepted
    task automatic fill(output int acc);
        acc = 0;
        for (int i = 0; i < 20; i++) begin
            lsu_data = 64'h100 + 64'(acc);
            if (!lsu_ready) break;
            acc++;
            cyc();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int acc;
        int n_alu;
        logic [63:0] exp_d;
        logic [4:0] exp_rd [9];
        exp_rd = '{5'd1, 5'd2, 5'd1, 5'd2, 5'd1, 5'd2, 5'd2, 5'd2, 5'd2};
        alu_valid = 0; alu_rd = 0; alu_data = 0;
        lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
        iss_valid = 0; iss_rd = 0;
        repeat (2) cyc();
        check("rst_en", rf_w_en, 0);
        check("rst_reg", rf_w_reg, 0);
        check("rst_data", rf_w_data, 0);
        check("rst_busy", busy, 0);
        check("rst_lsu_ready", lsu_ready, 1);
        check("rst_alu_ready", alu_ready, 1);
        rstn = 1;
        cyc();

        // ALU only: one-cycle latency
        alu_valid = 1; alu_rd = 5; alu_data = 64'h1234;
        check("t1_alu_ready", alu_ready, 1);
        cyc();
        check("t1_en", rf_w_en, 1);
        check("t1_reg", rf_w_reg, 5);
        check("t1_data", rf_w_data, 64'h1234);
        alu_valid = 0;
        cyc();
        check("t1_idle_en", rf_w_en, 0);
        check("t1_hold_reg", rf_w_reg, 5);
        check("t1_hold_data", rf_w_data, 64'h1234);

        // x0 write accepted but dropped
        alu_valid = 1; alu_rd = 0; alu_data = 64'hFFFF;
        check("t2_alu_ready", alu_ready, 1);
        cyc();
        check("t2_en", rf_w_en, 0);
        check("t2_busy", busy, 0);
        alu_valid = 0;

        // contention: ALU rd1 vs LSU rd2 every cycle, then drain
        wr_rd_q.delete(); wr_data_q.delete();
        alu_valid = 1; alu_rd = 1; alu_data = 64'hA1;
        lsu_valid = 1; lsu_rd = 2; lsu_data = 64'hB2;
        repeat (6) cyc();
        alu_valid = 0; lsu_valid = 0;
        repeat (6) cyc();
        check("t3_nwr", 64'(wr_rd_q.size()), 9);
        for (int i = 0; i < 9 && i < wr_rd_q.size(); i++)
            check($sformatf("t3_rd%0d", i), 64'(wr_rd_q[i]), 64'(exp_rd[i]));

        // fill the load buffer while ALU keeps competing
        wr_rd_q.delete(); wr_data_q.delete();
        alu_valid = 1; alu_rd = 3; alu_data = 64'hC3;
        lsu_valid = 1; lsu_rd = 4;
        fill(acc);
        check("t4_acc", 64'(acc), 7);
        check("t4_full", lsu_ready, 0);
        check("t4_alu_stall", alu_ready, 0);
        cyc();
        check("t4_ready_after_pop", lsu_ready, 1);
        alu_valid = 0; lsu_valid = 0;
        repeat (6) cyc();
        n_alu = 0;
        exp_d = 64'h100;
        foreach (wr_rd_q[i]) begin
            if (wr_rd_q[i] == 5'd4) begin
                check($sformatf("t4_ord%0d", i), wr_data_q[i], exp_d);
                exp_d++;
            end else n_alu++;
        end
        check("t4_nlsu", exp_d - 64'h100, 7);
        check("t4_nalu", 64'(n_alu), 4);

        // scoreboard set, clear, x0 ignore, set beats clear
        iss_valid = 1; iss_rd = 7;
        cyc();
        check("t5_set", busy, 32'h80);
        iss_rd = 0;
        cyc();
        check("t5_x0", busy, 32'h80);
        iss_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 64'h77;
        cyc();
        alu_valid = 0;
        check("t5_wr_en", rf_w_en, 1);
        check("t5_still_busy", busy, 32'h80);
        cyc();
        check("t5_clear", busy, 0);
        iss_valid = 1; iss_rd = 7;
        cyc();
        iss_valid = 0;
        alu_valid = 1; alu_rd = 7; alu_data = 64'h78;
        cyc();
        alu_valid = 0;
        check("t5_wr_en2", rf_w_en, 1);
        iss_valid = 1; iss_rd = 7;
        cyc();
        iss_valid = 0;
        check("t5_set_wins", busy, 32'h80);
        cyc();
        check("t5_set_holds", busy, 32'h80);

        // reset while loads are queued
        alu_valid = 1; alu_rd = 3; alu_data = 64'hC3;
        lsu_valid = 1; lsu_rd = 4;
        fill(acc);
        check("t6_full", lsu_ready, 0);
        alu_valid = 0; lsu_valid = 0;
        check("t6_busy_pre", busy, 32'h80);
        #2 rstn = 0;
        #1;
        check("t6_en", rf_w_en, 0);
        check("t6_reg", rf_w_reg, 0);
        check("t6_data", rf_w_data, 0);
        check("t6_busy", busy, 0);
        check("t6_lsu_ready", lsu_ready, 1);
        cyc();
        rstn = 1;
        wr_rd_q.delete(); wr_data_q.delete();
        repeat (8) cyc();
        check("t6_no_stale", 64'(wr_rd_q.size()), 0);
        check("t6_alu_ready", alu_ready, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
